// File: rtl/store_unit.sv
// -----------------------------------------------------------------------------
// store_unit
//   Store-side memory writer for the RV32I core. Takes one SB/SH/SW request
//   from execute, checks alignment, lane-replicates the store data, forms
//   byte strobes and drives a single-outstanding valid/ack write to data
//   memory. The pipeline is held while the write is in flight. Misaligned
//   requests and bus timeouts are reported as one-cycle pulses.
//
// Ports
//   clk_in           clock, all state changes on the rising edge
//   rst_in           synchronous reset, active-low
//   st_valid_in      store request present (sampled when st_ready_out=1)
//   funct3_in        000=SB, 001=SH, 010=SW, others illegal
//   iadder_in        effective byte address
//   rs2_in           store data source
//   st_ready_out     unit idle; request accepted this cycle if st_valid_in=1
//   stall_out        pipeline hold while the write is in flight
//   dmem_addr_out    word-aligned address
//   dmem_wdata_out   lane-replicated store data
//   dmem_wr_mask_out byte strobes, bit i = byte lane i
//   dmem_wr_req_out  write request valid
//   dmem_ack_in      memory accepted/completed the write this cycle
//   st_done_out      one-cycle pulse: store completed
//   misaligned_out   one-cycle pulse: misaligned/illegal store dropped
//   bus_err_out      one-cycle pulse: timeout, store abandoned
// -----------------------------------------------------------------------------
module store_unit #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        st_valid_in,
  input  logic [2:0]  funct3_in,
  input  logic [31:0] iadder_in,
  input  logic [31:0] rs2_in,
  output logic        st_ready_out,
  output logic        stall_out,
  output logic [31:0] dmem_addr_out,
  output logic [31:0] dmem_wdata_out,
  output logic [3:0]  dmem_wr_mask_out,
  output logic        dmem_wr_req_out,
  input  logic        dmem_ack_in,
  output logic        st_done_out,
  output logic        misaligned_out,
  output logic        bus_err_out
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } state_t;

  localparam logic [2:0]       LP_SB   = 3'b000;
  localparam logic [2:0]       LP_SH   = 3'b001;
  localparam logic [2:0]       LP_SW   = 3'b010;
  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;

  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;
  logic [3:0]       r_mask;
  logic             r_wr_req;
  logic             r_done;
  logic             r_misaligned;
  logic             r_bus_err;

  logic             w_legal;
  logic [31:0]      w_wdata;
  logic [3:0]       w_mask;
  logic             w_accept;
  logic             w_reject;
  logic             w_ack_exit;
  logic             w_timeout;

  // Legality, data replication and strobe formation for the incoming request.
  always_comb begin
    w_legal = 1'b0;
    w_wdata = '0;
    w_mask  = '0;
    case (funct3_in)
      LP_SB: begin
        w_legal = 1'b1;
        w_wdata = {4{rs2_in[7:0]}};
        w_mask  = 4'b0001 << iadder_in[1:0];
      end
      LP_SH: begin
        w_legal = ~iadder_in[0];
        w_wdata = {2{rs2_in[15:0]}};
        w_mask  = iadder_in[1] ? 4'b1100 : 4'b0011;
      end
      LP_SW: begin
        w_legal = (iadder_in[1:0] == 2'b00);
        w_wdata = rs2_in;
        w_mask  = 4'b1111;
      end
      default: begin
        w_legal = 1'b0;
      end
    endcase
  end

  assign w_accept   = (r_state == S_IDLE) && st_valid_in && w_legal;
  assign w_reject   = (r_state == S_IDLE) && st_valid_in && !w_legal;
  // Ack has priority over a timeout landing on the same cycle.
  assign w_ack_exit = (r_state == S_REQ) && dmem_ack_in;
  assign w_timeout  = (r_state == S_REQ) && !dmem_ack_in && (r_cnt == LP_LAST);

  // State register
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_next = S_REQ;
        end
      end
      S_REQ: begin
        if (w_ack_exit || w_timeout) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Registered bus-side outputs, status pulses and timeout counter
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_cnt        <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_mask       <= '0;
      r_wr_req     <= 1'b0;
      r_done       <= 1'b0;
      r_misaligned <= 1'b0;
      r_bus_err    <= 1'b0;
    end else begin
      r_done       <= 1'b0;
      r_misaligned <= 1'b0;
      r_bus_err    <= 1'b0;
      if (w_accept) begin
        r_addr   <= {iadder_in[31:2], 2'b00};
        r_wdata  <= w_wdata;
        r_mask   <= w_mask;
        r_wr_req <= 1'b1;
        r_cnt    <= '0;
      end else if (w_reject) begin
        r_misaligned <= 1'b1;
      end else if (w_ack_exit) begin
        r_done   <= 1'b1;
        r_wr_req <= 1'b0;
        r_mask   <= '0;
        r_cnt    <= '0;
      end else if (w_timeout) begin
        r_bus_err <= 1'b1;
        r_wr_req  <= 1'b0;
        r_mask    <= '0;
        r_cnt     <= '0;
      end else if (r_state == S_REQ) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Output decode from state
  always_comb begin
    st_ready_out = (r_state == S_IDLE);
    stall_out    = (r_state == S_REQ);
  end

  assign dmem_addr_out    = r_addr;
  assign dmem_wdata_out   = r_wdata;
  assign dmem_wr_mask_out = r_mask;
  assign dmem_wr_req_out  = r_wr_req;
  assign st_done_out      = r_done;
  assign misaligned_out   = r_misaligned;
  assign bus_err_out      = r_bus_err;

endmodule

// File: tb/tb_store_unit.sv
// -----------------------------------------------------------------------------
// tb_store_unit
//   Directed self-checking bench for store_unit. Inputs are driven and outputs
//   sampled 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_store_unit;

  logic        clk_in;
  logic        rst_in;
  logic        st_valid_in;
  logic [2:0]  funct3_in;
  logic [31:0] iadder_in;
  logic [31:0] rs2_in;
  logic        st_ready_out;
  logic        stall_out;
  logic [31:0] dmem_addr_out;
  logic [31:0] dmem_wdata_out;
  logic [3:0]  dmem_wr_mask_out;
  logic        dmem_wr_req_out;
  logic        dmem_ack_in;
  logic        st_done_out;
  logic        misaligned_out;
  logic        bus_err_out;

  int unsigned n_checks;
  int unsigned n_fail;
  int unsigned n_req;

  store_unit #(
    .TIMEOUT_CYCLES(16),
    .CNT_W         (5)
  ) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .st_valid_in     (st_valid_in),
    .funct3_in       (funct3_in),
    .iadder_in       (iadder_in),
    .rs2_in          (rs2_in),
    .st_ready_out    (st_ready_out),
    .stall_out       (stall_out),
    .dmem_addr_out   (dmem_addr_out),
    .dmem_wdata_out  (dmem_wdata_out),
    .dmem_wr_mask_out(dmem_wr_mask_out),
    .dmem_wr_req_out (dmem_wr_req_out),
    .dmem_ack_in     (dmem_ack_in),
    .st_done_out     (st_done_out),
    .misaligned_out  (misaligned_out),
    .bus_err_out     (bus_err_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    st_valid_in = v;
    funct3_in   = f3;
    iadder_in   = a;
    rs2_in      = d;
  endtask

  // Issue one legal store, check the REQ-cycle bus image, ack it in the first
  // REQ cycle and check the done pulse.
  task automatic store_ack(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] d, input logic [31:0] exp_addr,
                           input logic [31:0] exp_data, input logic [3:0] exp_mask);
    drive(1'b1, f3, a, d);
    check_eq({tag, "_ready_idle"}, {31'b0, st_ready_out}, 32'd1);
    tick();
    drive(1'b0, 3'b000, 32'h0, 32'h0);
    check_eq({tag, "_req"},   {31'b0, dmem_wr_req_out}, 32'd1);
    check_eq({tag, "_stall"}, {31'b0, stall_out}, 32'd1);
    check_eq({tag, "_addr"},  dmem_addr_out, exp_addr);
    check_eq({tag, "_wdata"}, dmem_wdata_out, exp_data);
    check_eq({tag, "_mask"},  {28'b0, dmem_wr_mask_out}, {28'b0, exp_mask});
    dmem_ack_in = 1'b1;
    tick();
    dmem_ack_in = 1'b0;
    check_eq({tag, "_done"},     {31'b0, st_done_out}, 32'd1);
    check_eq({tag, "_req_off"},  {31'b0, dmem_wr_req_out}, 32'd0);
    check_eq({tag, "_mask_off"}, {28'b0, dmem_wr_mask_out}, 32'd0);
    check_eq({tag, "_stall_off"},{31'b0, stall_out}, 32'd0);
    tick();
    check_eq({tag, "_done_pulse"}, {31'b0, st_done_out}, 32'd0);
  endtask

  task automatic bad_store(input string tag, input logic [2:0] f3, input logic [31:0] a);
    drive(1'b1, f3, a, 32'hCAFE_F00D);
    tick();
    drive(1'b0, 3'b000, 32'h0, 32'h0);
    check_eq({tag, "_mis"},   {31'b0, misaligned_out}, 32'd1);
    check_eq({tag, "_req"},   {31'b0, dmem_wr_req_out}, 32'd0);
    check_eq({tag, "_ready"}, {31'b0, st_ready_out}, 32'd1);
    tick();
    check_eq({tag, "_mis_pulse"}, {31'b0, misaligned_out}, 32'd0);
    check_eq({tag, "_req2"},      {31'b0, dmem_wr_req_out}, 32'd0);
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rst_in      = 1'b0;
    dmem_ack_in = 1'b0;
    drive(1'b0, 3'b000, 32'h0, 32'h0);
    tick();
    tick();

    // Reset state
    check_eq("rst_ready", {31'b0, st_ready_out}, 32'd1);
    check_eq("rst_stall", {31'b0, stall_out}, 32'd0);
    check_eq("rst_addr",  dmem_addr_out, 32'h0);
    check_eq("rst_wdata", dmem_wdata_out, 32'h0);
    check_eq("rst_mask",  {28'b0, dmem_wr_mask_out}, 32'd0);
    check_eq("rst_req",   {31'b0, dmem_wr_req_out}, 32'd0);
    check_eq("rst_flags", {29'b0, st_done_out, misaligned_out, bus_err_out}, 32'd0);
    rst_in = 1'b1;
    tick();

    // Ack while idle is ignored
    dmem_ack_in = 1'b1;
    tick();
    dmem_ack_in = 1'b0;
    check_eq("idle_ack_done", {31'b0, st_done_out}, 32'd0);
    check_eq("idle_ack_req",  {31'b0, dmem_wr_req_out}, 32'd0);

    // Legal stores with hand-computed bus images
    store_ack("sw1004", 3'b010, 32'h0000_1004, 32'hDEAD_BEEF, 32'h0000_1004, 32'hDEAD_BEEF, 4'b1111);
    store_ack("sb2003", 3'b000, 32'h0000_2003, 32'h0000_00A5, 32'h0000_2000, 32'hA5A5_A5A5, 4'b1000);
    store_ack("sb2001", 3'b000, 32'h0000_2001, 32'h1234_5677, 32'h0000_2000, 32'h7777_7777, 4'b0010);
    store_ack("sh2002", 3'b001, 32'h0000_2002, 32'h0000_1234, 32'h0000_2000, 32'h1234_1234, 4'b1100);
    store_ack("sh2000", 3'b001, 32'h0000_2000, 32'hFFFF_ABCD, 32'h0000_2000, 32'hABCD_ABCD, 4'b0011);

    // Illegal requests
    bad_store("sh3001", 3'b001, 32'h0000_3001);
    bad_store("sw3002", 3'b010, 32'h0000_3002);
    bad_store("f3_011", 3'b011, 32'h0000_3000);

    // Timeout: no ack, wr_req must stay high exactly 16 cycles
    drive(1'b1, 3'b010, 32'h0000_4000, 32'h5555_AAAA);
    tick();
    drive(1'b0, 3'b000, 32'h0, 32'h0);
    n_req = 0;
    for (int i = 0; i < 40; i++) begin
      if (!dmem_wr_req_out) break;
      n_req++;
      tick();
    end
    check_eq("to_req_cycles", n_req, 32'd16);
    check_eq("to_bus_err",    {31'b0, bus_err_out}, 32'd1);
    check_eq("to_done",       {31'b0, st_done_out}, 32'd0);
    check_eq("to_ready",      {31'b0, st_ready_out}, 32'd1);
    check_eq("to_mask",       {28'b0, dmem_wr_mask_out}, 32'd0);
    tick();
    check_eq("to_err_pulse",  {31'b0, bus_err_out}, 32'd0);

    // Ack on the 16th REQ cycle wins over timeout
    drive(1'b1, 3'b010, 32'h0000_4004, 32'h0F0F_0F0F);
    tick();
    drive(1'b0, 3'b000, 32'h0, 32'h0);
    for (int i = 0; i < 15; i++) tick();
    check_eq("late_req_held", {31'b0, dmem_wr_req_out}, 32'd1);
    dmem_ack_in = 1'b1;
    tick();
    dmem_ack_in = 1'b0;
    check_eq("late_done",    {31'b0, st_done_out}, 32'd1);
    check_eq("late_bus_err", {31'b0, bus_err_out}, 32'd0);
    check_eq("late_req_off", {31'b0, dmem_wr_req_out}, 32'd0);
    tick();

    // Back-to-back with ack tied high
    dmem_ack_in = 1'b1;
    drive(1'b1, 3'b010, 32'h0000_0010, 32'h1111_1111);
    tick();
    check_eq("b2b_req1",   {31'b0, dmem_wr_req_out}, 32'd1);
    check_eq("b2b_addr1",  dmem_addr_out, 32'h0000_0010);
    check_eq("b2b_data1",  dmem_wdata_out, 32'h1111_1111);
    // Second request presented during REQ; it must wait for the done cycle
    drive(1'b1, 3'b010, 32'h0000_0014, 32'h2222_2222);
    tick();
    check_eq("b2b_done1",  {31'b0, st_done_out}, 32'd1);
    check_eq("b2b_gap",    {31'b0, dmem_wr_req_out}, 32'd0);
    check_eq("b2b_ready",  {31'b0, st_ready_out}, 32'd1);
    tick();
    drive(1'b0, 3'b000, 32'h0, 32'h0);
    check_eq("b2b_req2",   {31'b0, dmem_wr_req_out}, 32'd1);
    check_eq("b2b_addr2",  dmem_addr_out, 32'h0000_0014);
    check_eq("b2b_data2",  dmem_wdata_out, 32'h2222_2222);
    check_eq("b2b_nodone", {31'b0, st_done_out}, 32'd0);
    tick();
    check_eq("b2b_done2",  {31'b0, st_done_out}, 32'd1);
    check_eq("b2b_req2off",{31'b0, dmem_wr_req_out}, 32'd0);
    tick();
    check_eq("b2b_no_third", {31'b0, dmem_wr_req_out}, 32'd0);
    dmem_ack_in = 1'b0;
    tick();

    // Reset on the 3rd REQ cycle abandons the write silently
    drive(1'b1, 3'b010, 32'h0000_5000, 32'h7777_8888);
    tick();
    drive(1'b0, 3'b000, 32'h0, 32'h0);
    tick();
    tick();
    check_eq("mr_req_before", {31'b0, dmem_wr_req_out}, 32'd1);
    rst_in = 1'b0;
    tick();
    rst_in = 1'b1;
    check_eq("mr_req",   {31'b0, dmem_wr_req_out}, 32'd0);
    check_eq("mr_mask",  {28'b0, dmem_wr_mask_out}, 32'd0);
    check_eq("mr_stall", {31'b0, stall_out}, 32'd0);
    check_eq("mr_ready", {31'b0, st_ready_out}, 32'd1);
    check_eq("mr_flags", {30'b0, st_done_out, bus_err_out}, 32'd0);
    tick();
    check_eq("mr_flags2", {30'b0, st_done_out, bus_err_out}, 32'd0);
    check_eq("mr_req2",   {31'b0, dmem_wr_req_out}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time guard so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
